// File: rtl/piradip_latency_credit_buffer.sv
// Credit-managed landing FIFO for a fixed-latency, non-stallable pipeline.
// Credits bound launches so every beat that emerges always has a slot waiting for it.
module piradip_latency_credit_buffer #(
  parameter int DATA_WIDTH   = 33,
  parameter int DEPTH        = 8,
  parameter int CREDIT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic                    pipe_valid,
  input  logic [DATA_WIDTH-1:0]   pipe_data,
  output logic                    m_valid,
  output logic [DATA_WIDTH-1:0]   m_data,
  input  logic                    m_ready,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic [CREDIT_WIDTH-1:0] count,
  output logic                    overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CREDIT_WIDTH-1:0] DEPTH_C = CREDIT_WIDTH'(DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] ONE_C   = CREDIT_WIDTH'(1);
  localparam logic [PTR_W-1:0]        PTR_ONE = PTR_W'(1);

  // Handshakes: a transfer happens on a cycle where valid & ready are both high.
  // issue and m are true valid/ready pairs; pipe has no ready because the
  // pipeline cannot stall, so a pipe_valid beat arriving on a full FIFO is lost.

  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic [CREDIT_WIDTH-1:0] count_q, count_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic                    overflow_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic issue_fire;
  logic push;
  logic pop;
  logic full;
  logic push_accepted;
  logic push_dropped;

  assign issue_ready   = (credits_q != '0);
  assign m_valid       = (count_q != '0);
  assign m_data        = mem[rd_ptr_q];
  assign credits       = credits_q;
  assign count         = count_q;
  assign overflow      = overflow_q;

  assign issue_fire    = issue_valid & issue_ready;
  assign push          = pipe_valid;
  assign pop           = m_valid & m_ready;
  assign full          = (count_q == DEPTH_C);
  // A full FIFO can still take a beat when the head leaves in the same cycle.
  assign push_accepted = push & (~full | pop);
  assign push_dropped  = push & full & ~pop;

  // Credits saturate at DEPTH so an unissued beat being drained cannot mint extra credit.
  always_comb begin
    credits_d = credits_q;
    if (issue_fire && !pop) begin
      credits_d = credits_q - ONE_C;
    end else if (pop && !issue_fire && (credits_q != DEPTH_C)) begin
      credits_d = credits_q + ONE_C;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_accepted && !pop) begin
      count_d = count_q + ONE_C;
    end else if (pop && !push_accepted) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      credits_q  <= DEPTH_C;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      if (push_accepted) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push_dropped) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; contents are only observed while m_valid is high.
  always_ff @(posedge clk) begin
    if (push_accepted) begin
      mem[wr_ptr_q] <= pipe_data;
    end
  end

endmodule

// File: tb/tb_piradip_latency_credit_buffer.sv
// Directed bench: a 3-stage pipeline model feeds the buffer; expected values are hand-derived.
module tb_piradip_latency_credit_buffer;

  localparam int DW    = 33;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk;
  logic          resetn;
  logic          issue_valid;
  logic          issue_ready;
  logic          pipe_valid;
  logic [DW-1:0] pipe_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] credits;
  logic [CW-1:0] count;
  logic          overflow;

  logic          force_en;
  logic          force_valid;
  logic [DW-1:0] force_data;

  logic [2:0]    pv;
  logic [DW-1:0] pd [3];
  logic [DW-1:0] seq;

  int checks;
  int errors;
  int got;

  piradip_latency_credit_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .CREDIT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .pipe_valid(pipe_valid),
    .pipe_data(pipe_data),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .credits(credits),
    .count(count),
    .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fixed-latency upstream pipeline (3 stages), reset together with the buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pv    <= '0;
      pd[0] <= '0;
      pd[1] <= '0;
      pd[2] <= '0;
      seq   <= '0;
    end else begin
      pv    <= {pv[1:0], issue_valid & issue_ready};
      pd[0] <= seq;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      if (issue_valid && issue_ready) seq <= seq + 1'b1;
    end
  end

  assign pipe_valid = force_en ? force_valid : pv[2];
  assign pipe_data  = force_en ? force_data  : pd[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inv(input string tag);
    logic [63:0] total;
    total = 64'(credits) + 64'(count) + 64'(pv[0]) + 64'(pv[1]) + 64'(pv[2]);
    check(tag, total, 64'(DEPTH));
  endtask

  // driver tasks: all start and end on a falling edge
  task automatic do_reset();
    resetn      = 1'b0;
    issue_valid = 1'b0;
    m_ready     = 1'b0;
    force_en    = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic fill();
    for (int i = 0; i < DEPTH; i++) begin
      issue_valid = 1'b1;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("fill_count", 64'(count), 64'(8));
    check("fill_credits", 64'(credits), 64'(0));
  endtask

  task automatic drain(input int base);
    m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", 64'(m_data), 64'(base + i));
      @(negedge clk);
    end
    m_ready = 1'b0;
    check("drain_count", 64'(count), 64'(0));
    check("drain_credits", 64'(credits), 64'(8));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks      = 0;
    errors      = 0;
    got         = 0;
    resetn      = 1'b0;
    issue_valid = 1'b0;
    m_ready     = 1'b0;
    force_en    = 1'b0;
    force_valid = 1'b0;
    force_data  = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_credits", 64'(credits), 64'(8));
    check("rst_count", 64'(count), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_issue_ready", 64'(issue_ready), 64'(1));
    check("rst_overflow", 64'(overflow), 64'(0));
    resetn = 1'b1;

    // eight back-to-back issues, consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("t1_credits", 64'(credits), 64'(8 - i));
      issue_valid = 1'b1;
    end
    @(negedge clk);
    check("t1_credits_empty", 64'(credits), 64'(0));
    check("t1_issue_ready", 64'(issue_ready), 64'(0));
    check("t1_count5", 64'(count), 64'(5));
    check_inv("t1_inv_a");
    @(negedge clk);
    check("t1_ignored_issue", 64'(credits), 64'(0));
    check("t1_count6", 64'(count), 64'(6));
    issue_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_count8", 64'(count), 64'(8));
    check("t1_m_valid", 64'(m_valid), 64'(1));
    check("t1_head", 64'(m_data), 64'(0));
    check("t1_overflow", 64'(overflow), 64'(0));
    check_inv("t1_inv_b");

    // single pop from full
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("t2_count", 64'(count), 64'(7));
    check("t2_credits", 64'(credits), 64'(1));
    check("t2_issue_ready", 64'(issue_ready), 64'(1));
    check("t2_head", 64'(m_data), 64'(1));

    // top up to full again
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_pre_count", 64'(count), 64'(8));
    check("t4_pre_credits", 64'(credits), 64'(0));

    // push on full without pop: dropped, overflow sticky
    force_en    = 1'b1;
    force_valid = 1'b1;
    force_data  = 33'h0AA;
    @(negedge clk);
    force_en = 1'b0;
    check("t4_overflow", 64'(overflow), 64'(1));
    check("t4_count", 64'(count), 64'(8));
    check("t4_head", 64'(m_data), 64'(1));
    check("t4_credits", 64'(credits), 64'(0));
    @(negedge clk);
    check("t4_overflow_sticky", 64'(overflow), 64'(1));
    do_reset();
    check("t4_overflow_cleared", 64'(overflow), 64'(0));
    check("t4_rst_credits", 64'(credits), 64'(8));

    // push and pop together on full
    fill();
    force_en    = 1'b1;
    force_valid = 1'b1;
    force_data  = 33'h055;
    m_ready     = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    m_ready  = 1'b0;
    check("t5_count", 64'(count), 64'(8));
    check("t5_overflow", 64'(overflow), 64'(0));
    check("t5_head", 64'(m_data), 64'(1));
    check("t5_credits", 64'(credits), 64'(1));
    m_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      check("t5_drain_data", 64'(m_data), 64'(i));
      @(negedge clk);
    end
    check("t5_tail_55", 64'(m_data), 64'(33'h055));
    @(negedge clk);
    m_ready = 1'b0;
    check("t5_count_empty", 64'(count), 64'(0));
    check("t5_m_valid", 64'(m_valid), 64'(0));
    check("t5_credits_sat", 64'(credits), 64'(8));

    // pointer wrap over three fill/drain rounds
    for (int c = 0; c < 3; c++) begin
      fill();
      drain(8 + 8 * c);
    end

    // continuous streaming of 100 beats
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 110; k++) begin
      check("t3_m_valid", 64'(m_valid), 64'((k >= 4 && k <= 103) ? 1 : 0));
      if (m_valid) begin
        check("t3_data", 64'(m_data), 64'(got));
        got++;
      end
      check("t3_credits_min", 64'(credits >= 4'd4), 64'(1));
      check("t3_count_max", 64'(count <= 4'd1), 64'(1));
      check_inv("t3_inv");
      issue_valid = (k < 100);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    m_ready     = 1'b0;
    check("t3_beats", 64'(got), 64'(100));
    check("t3_end_credits", 64'(credits), 64'(8));

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue_valid = 1'b1;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_pre_count", 64'(count), 64'(5));
    check("t6_pre_credits", 64'(credits), 64'(2));
    #2;
    resetn = 1'b0;
    #1;
    check("t6_async_count", 64'(count), 64'(0));
    check("t6_async_m_valid", 64'(m_valid), 64'(0));
    check("t6_async_credits", 64'(credits), 64'(8));
    check("t6_async_issue_ready", 64'(issue_ready), 64'(1));
    @(negedge clk);
    resetn      = 1'b1;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_resume_m_valid", 64'(m_valid), 64'(1));
    check("t6_resume_data", 64'(m_data), 64'(0));
    check("t6_resume_count", 64'(count), 64'(1));
    check("t6_resume_credits", 64'(credits), 64'(7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
